i8253_control: RTL

- CPU-side control/bus-interface block for the three-channel i8253 timer.
- Decodes byte-wide port reads and writes into per-channel configuration and load strobes for three i8253_counter instances.
- Holds per-channel RW format, mode and BCD, the byte-sequencing toggles and the counter-latch registers.
- Sits between the I/O decoder and the counter datapath.

---
 rtl/i8253_pkg.sv | 35 +++
 rtl/i8253_channel_ctrl.sv | 163 ++++++++++++++++
 rtl/i8253_control.sv | 113 +++++++++++
 3 files changed

// File: rtl/i8253_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// i8253_pkg : shared encodings for the i8253 control block
// Rev 1.0
// ------------------------------------------------------------------
package i8253_pkg;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  localparam logic [1:0] ADDR_CNT0 = 2'd0;
  localparam logic [1:0] ADDR_CNT1 = 2'd1;
  localparam logic [1:0] ADDR_CNT2 = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  // Read-back status byte layout
  localparam int ST_OUT  = 7;
  localparam int ST_NULL = 6;
  localparam int ST_RW   = 4;
  localparam int ST_MODE = 1;
  localparam int ST_BCD  = 0;

  // Modes 6 and 7 alias modes 2 and 3
  function automatic logic [5:0] mode_decode(input logic [2:0] m);
    case (m)
      3'd6:    return 6'b000100;
      3'd7:    return 6'b001000;
      default: return 6'b000001 << m;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i8253_channel_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// i8253_channel_ctrl : per-channel config, byte toggles, count/status latch
// Rev 1.0
// ------------------------------------------------------------------
module i8253_channel_ctrl
  import i8253_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cw_wr,
  input  logic        latch_cmd,
  input  logic        status_cmd,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [5:0]  cw_bits,
  input  logic [15:0] count,
  input  logic        out_pin,
  input  logic        clk_en,
  output logic        wr_cw,
  output logic        wr_lsb,
  output logic        wr_msb,
  output logic        wr_trigger,
  output logic [5:0]  mode,
  output logic        bcd,
  output logic [7:0]  rd_byte
);

  logic [1:0]  rw;
  logic        wr_tog;
  logic        rd_tog;
  logic        latched;
  logic [15:0] latch_val;
  logic        st_pending;
  logic [7:0]  st_val;

  logic lsb_n, msb_n, trig_n;

  always_comb begin
    lsb_n  = 1'b0;
    msb_n  = 1'b0;
    trig_n = 1'b0;
    if (data_wr) begin
      case (rw)
        RW_LSB:  begin lsb_n = 1'b1; trig_n = 1'b1; end
        RW_MSB:  begin msb_n = 1'b1; trig_n = 1'b1; end
        RW_WORD: begin
          lsb_n  = ~wr_tog;
          msb_n  = wr_tog;
          trig_n = wr_tog;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw         <= RW_LSB;
      mode       <= '0;
      bcd        <= 1'b0;
      wr_tog     <= 1'b0;
      rd_tog     <= 1'b0;
      latched    <= 1'b0;
      latch_val  <= '0;
      wr_cw      <= 1'b0;
      wr_lsb     <= 1'b0;
      wr_msb     <= 1'b0;
      wr_trigger <= 1'b0;
    end else begin
      wr_cw      <= cw_wr;
      wr_lsb     <= lsb_n;
      wr_msb     <= msb_n;
      wr_trigger <= trig_n;
      if (cw_wr) begin
        rw      <= cw_bits[5:4];
        mode    <= mode_decode(cw_bits[3:1]);
        bcd     <= cw_bits[0];
        wr_tog  <= 1'b0;
        rd_tog  <= 1'b0;
        latched <= 1'b0;
      end else if (latch_cmd && !latched) begin
        latch_val <= count;
        latched   <= 1'b1;
      end
      if (data_wr && rw == RW_WORD)
        wr_tog <= ~wr_tog;
      // A pending status byte is consumed first without advancing the count sequence
      if (data_rd && !st_pending) begin
        if (rw == RW_WORD) begin
          rd_tog <= ~rd_tog;
          if (rd_tog) latched <= 1'b0;
        end else begin
          latched <= 1'b0;
        end
      end
    end
  end

`ifdef I8254_READBACK_EN
  logic [2:0] m_raw;
  logic       null_cnt;
  logic       armed;
  logic [7:0] st_now;

  always_comb begin
    st_now               = '0;
    st_now[ST_OUT]       = out_pin;
    st_now[ST_NULL]      = null_cnt;
    st_now[ST_RW +: 2]   = rw;
    st_now[ST_MODE +: 3] = m_raw;
    st_now[ST_BCD]       = bcd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_raw      <= '0;
      null_cnt   <= 1'b0;
      armed      <= 1'b0;
      st_pending <= 1'b0;
      st_val     <= '0;
    end else begin
      if (cw_wr) begin
        m_raw    <= cw_bits[3:1];
        null_cnt <= 1'b1;
        armed    <= 1'b0;
      end else if (trig_n) begin
        null_cnt <= 1'b1;
        armed    <= 1'b1;
      end else if (clk_en && armed) begin
        null_cnt <= 1'b0;
        armed    <= 1'b0;
      end
      if (cw_wr) begin
        st_pending <= 1'b0;
      end else if (status_cmd && !st_pending) begin
        st_pending <= 1'b1;
        st_val     <= st_now;
      end else if (data_rd && st_pending) begin
        st_pending <= 1'b0;
      end
    end
  end
`else
  logic unused_rb;
  assign unused_rb  = ^{status_cmd, out_pin, clk_en};
  assign st_pending = 1'b0;
  assign st_val     = '0;
`endif

  logic [15:0] src;
  always_comb begin
    src = latched ? latch_val : count;
    if (st_pending)
      rd_byte = st_val;
    else if (rw == RW_MSB || (rw == RW_WORD && rd_tog))
      rd_byte = src[15:8];
    else
      rd_byte = src[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/i8253_control.sv
`default_nettype none
// ------------------------------------------------------------------
// i8253_control : CPU bus decode and rdata mux for three i8253 channels
// Optional 8254 read-back command: define I8254_READBACK_EN.  Rev 1.0
// ------------------------------------------------------------------
module i8253_control
  import i8253_pkg::*;
#(
  parameter logic [7:0] RDATA_IDLE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        wrreq,
  input  logic        rdreq,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic [15:0] counter0,
  input  logic [15:0] counter1,
  input  logic [15:0] counter2,
  input  logic [2:0]  out_in,
  input  logic [2:0]  clk_en,
  output logic [7:0]  load_counter,
  output logic [2:0]  wr_cw,
  output logic [2:0]  wr_lsb,
  output logic [2:0]  wr_msb,
  output logic [2:0]  wr_trigger,
  output logic [2:0]  mode0,
  output logic [2:0]  mode1,
  output logic [2:0]  mode2,
  output logic [2:0]  mode3,
  output logic [2:0]  mode4,
  output logic [2:0]  mode5,
  output logic [2:0]  bcd
);

  logic       cw_sel;
  logic       rd_go;
  logic [7:0] rd_byte [3];
  logic [5:0] ch_mode [3];

  assign cw_sel = wrreq && address == ADDR_CTRL;
  // A write always wins over a simultaneous read
  assign rd_go  = rdreq && !wrreq;

  for (genvar n = 0; n < 3; n++) begin : g_ch
    logic [15:0] cnt;
    logic        sc_hit;
    logic        cw_wr_n;
    logic        latch_n;
    logic        status_n;

    assign cnt     = (n == 0) ? counter0 : (n == 1) ? counter1 : counter2;
    assign sc_hit  = cw_sel && wdata[7:6] == 2'(n);
    assign cw_wr_n = sc_hit && wdata[5:4] != RW_LATCH;
`ifdef I8254_READBACK_EN
    assign latch_n  = (sc_hit && wdata[5:4] == RW_LATCH) ||
                      (cw_sel && wdata[7:6] == 2'b11 && !wdata[5] && wdata[n+1]);
    assign status_n = cw_sel && wdata[7:6] == 2'b11 && !wdata[4] && wdata[n+1];
`else
    assign latch_n  = sc_hit && wdata[5:4] == RW_LATCH;
    assign status_n = 1'b0;
`endif

    i8253_channel_ctrl u_ch (
      .clk        (clk),
      .reset      (reset),
      .cw_wr      (cw_wr_n),
      .latch_cmd  (latch_n),
      .status_cmd (status_n),
      .data_wr    (wrreq && address == 2'(n)),
      .data_rd    (rd_go && address == 2'(n)),
      .cw_bits    (wdata[5:0]),
      .count      (cnt),
      .out_pin    (out_in[n]),
      .clk_en     (clk_en[n]),
      .wr_cw      (wr_cw[n]),
      .wr_lsb     (wr_lsb[n]),
      .wr_msb     (wr_msb[n]),
      .wr_trigger (wr_trigger[n]),
      .mode       (ch_mode[n]),
      .bcd        (bcd[n]),
      .rd_byte    (rd_byte[n])
    );

    assign mode0[n] = ch_mode[n][0];
    assign mode1[n] = ch_mode[n][1];
    assign mode2[n] = ch_mode[n][2];
    assign mode3[n] = ch_mode[n][3];
    assign mode4[n] = ch_mode[n][4];
    assign mode5[n] = ch_mode[n][5];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata        <= RDATA_IDLE;
      load_counter <= '0;
    end else begin
      if (wrreq && address != ADDR_CTRL)
        load_counter <= wdata;
      if (rd_go) begin
        case (address)
          ADDR_CNT0: rdata <= rd_byte[0];
          ADDR_CNT1: rdata <= rd_byte[1];
          ADDR_CNT2: rdata <= rd_byte[2];
          default:   rdata <= RDATA_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
